// File: rtl/uart_nibble_loader.sv
// uart_nibble_loader: turns a framed UART program download into nibble-wide program
// memory writes, holds the CPU halted meanwhile and verifies the byte-sum checksum.
module uart_nibble_loader #(
    parameter int UART_DATA_LENGTH = 8,
    parameter int NIBBLE_WIDTH = 4,
    parameter int ADDR_WIDTH = 5,
    parameter logic [UART_DATA_LENGTH-1:0] SYNC_BYTE = 8'hA5,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int TIMEOUT_BITWIDTH = 18
) (
    input  logic                        clk_i,
    input  logic                        reset_ni,
    input  logic [UART_DATA_LENGTH-1:0] rx_data_i,
    input  logic                        rx_valid_strb_i,
    output logic                        mem_we_o,
    output logic [ADDR_WIDTH-1:0]       mem_addr_o,
    output logic [NIBBLE_WIDTH-1:0]     mem_data_o,
    input  logic                        mem_ready_i,
    output logic                        cpu_halt_o,
    output logic                        load_done_o,
    output logic                        load_error_o,
    output logic [1:0]                  error_code_o
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN   = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_WR_LO = 3'd3;
    localparam logic [2:0] S_WR_HI = 3'd4;
    localparam logic [2:0] S_CHECK = 3'd5;
    localparam logic [1:0] E_NONE = 2'b00;
    localparam logic [1:0] E_LEN  = 2'b01;
    localparam logic [1:0] E_CHK  = 2'b10;
    localparam logic [1:0] E_OVR  = 2'b11;
    localparam logic [UART_DATA_LENGTH-1:0] MAX_LEN = UART_DATA_LENGTH'(2 ** (ADDR_WIDTH - 1));
    localparam logic [TIMEOUT_BITWIDTH-1:0] TO_LAST = TIMEOUT_BITWIDTH'(TIMEOUT_CYCLES - 1);

    logic [2:0]                  r_state;
    logic [ADDR_WIDTH-1:0]       r_addr;
    logic [ADDR_WIDTH-1:0]       r_count;
    logic [UART_DATA_LENGTH-1:0] r_sum;
    logic [NIBBLE_WIDTH-1:0]     r_hi;
    logic [NIBBLE_WIDTH-1:0]     r_data;
    logic [TIMEOUT_BITWIDTH-1:0] r_to_cnt;
    logic                        r_we;
    logic                        r_halt;
    logic                        r_done;
    logic                        r_err;
    logic [1:0]                  r_code;

    logic       w_wr;
    logic       w_cnt_st;
    logic       w_to;
    logic       w_bad_len;
    logic       w_fail;
    logic [1:0] w_code;

    always_comb begin
        w_wr      = (r_state == S_WR_LO) || (r_state == S_WR_HI);
        w_cnt_st  = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CHECK);
        w_to      = w_cnt_st && !rx_valid_strb_i && (r_to_cnt == TO_LAST);
        w_bad_len = (rx_data_i == '0) || (rx_data_i > MAX_LEN);
        w_fail    = w_to || (rx_valid_strb_i && (w_wr || (r_state == S_LEN && w_bad_len)
                    || (r_state == S_CHECK && rx_data_i != r_sum)));
        // a strobe while a write is pending and a silent line both count as overrun
        w_code    = (!rx_valid_strb_i || w_wr) ? E_OVR : (r_state == S_LEN) ? E_LEN : E_CHK;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_count <= '0;
            r_sum   <= '0;
            r_hi    <= '0;
            r_data  <= '0;
            r_we    <= 1'b0;
            r_halt  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_code  <= E_NONE;
        end else begin
            r_done <= 1'b0;
            if (w_fail) begin
                r_state <= S_IDLE;
                r_we    <= 1'b0;
                r_halt  <= 1'b0;
                r_err   <= 1'b1;
                r_code  <= w_code;
            end else begin
                case (r_state)
                    S_IDLE: if (rx_valid_strb_i && rx_data_i == SYNC_BYTE) begin
                        r_state <= S_LEN;
                        r_halt  <= 1'b1;
                        r_err   <= 1'b0;
                        r_code  <= E_NONE;
                        r_addr  <= '0;
                        r_sum   <= '0;
                    end
                    S_LEN: if (rx_valid_strb_i) begin
                        r_count <= rx_data_i[ADDR_WIDTH-1:0];
                        r_state <= S_DATA;
                    end
                    S_DATA: if (rx_valid_strb_i) begin
                        r_sum   <= r_sum + rx_data_i;
                        r_data  <= rx_data_i[NIBBLE_WIDTH-1:0];
                        r_hi    <= rx_data_i[UART_DATA_LENGTH-1:NIBBLE_WIDTH];
                        r_we    <= 1'b1;
                        r_state <= S_WR_LO;
                    end
                    S_WR_LO: if (mem_ready_i) begin
                        r_addr  <= r_addr + 1'b1;
                        r_data  <= r_hi;
                        r_state <= S_WR_HI;
                    end
                    S_WR_HI: if (mem_ready_i) begin
                        r_addr  <= r_addr + 1'b1;
                        r_count <= r_count - 1'b1;
                        r_we    <= 1'b0;
                        r_state <= (r_count == ADDR_WIDTH'(1)) ? S_CHECK : S_DATA;
                    end
                    S_CHECK: if (rx_valid_strb_i) begin
                        r_done  <= 1'b1;
                        r_halt  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // the inter-byte timer is frozen while a write is pending so memory stalls never time out
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni)
            r_to_cnt <= '0;
        else
            r_to_cnt <= w_wr ? r_to_cnt :
                        (w_cnt_st && !rx_valid_strb_i && !w_to) ? r_to_cnt + 1'b1 : '0;
    end

    assign mem_we_o     = r_we;
    assign mem_addr_o   = r_addr;
    assign mem_data_o   = r_data;
    assign cpu_halt_o   = r_halt;
    assign load_done_o  = r_done;
    assign load_error_o = r_err;
    assign error_code_o = r_code;
endmodule

// File: tb/tb_uart_nibble_loader.sv
// tb_uart_nibble_loader: directed frames with a write/result scoreboard drained by a monitor.
module tb_uart_nibble_loader;
    logic       clk_i = 1'b0;
    logic       reset_ni = 1'b0;
    logic [7:0] rx_data_i = 8'h00;
    logic       rx_valid_strb_i = 1'b0;
    logic       mem_ready_i = 1'b1;
    logic       mem_we_o;
    logic [4:0] mem_addr_o;
    logic [3:0] mem_data_o;
    logic       cpu_halt_o;
    logic       load_done_o;
    logic       load_error_o;
    logic [1:0] error_code_o;

    typedef struct packed {logic [4:0] a; logic [3:0] d;} wr_t;
    wr_t wq[$];
    int  rq[$];
    int  checks = 0;
    int  errors = 0;
    logic prev_err = 1'b0;
    wr_t  mw;
    int   mr;
    int   act;

    always #5 clk_i = ~clk_i;

    uart_nibble_loader #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .rx_data_i(rx_data_i),
        .rx_valid_strb_i(rx_valid_strb_i), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_ready_i(mem_ready_i), .cpu_halt_o(cpu_halt_o),
        .load_done_o(load_done_o), .load_error_o(load_error_o), .error_code_o(error_code_o)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk_i);
        #1 rx_data_i = b;
        rx_valid_strb_i = 1'b1;
        @(posedge clk_i);
        #1 rx_valid_strb_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic exp_wr(input logic [4:0] a, input logic [3:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        wq.push_back(w);
    endtask

    // result code 0 is a completed load, 1..3 are the error codes
    always @(negedge clk_i) begin
        if (reset_ni) begin
            if (mem_we_o && mem_ready_i) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0d data %0h, expected no write", mem_addr_o, mem_data_o);
                end else begin
                    mw = wq.pop_front();
                    check("wr_addr", mem_addr_o, mw.a);
                    check("wr_data", mem_data_o, mw.d);
                end
            end
            if (load_done_o || (load_error_o && !prev_err)) begin
                act = load_done_o ? (load_error_o ? 4 : 0) : int'(error_code_o);
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %0d, expected none", act);
                end else begin
                    mr = rq.pop_front();
                    check("result", act, mr);
                end
            end
            prev_err = load_error_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("rst_we", mem_we_o, 0);
        check("rst_addr", mem_addr_o, 0);
        check("rst_data", mem_data_o, 0);
        check("rst_halt", cpu_halt_o, 0);
        check("rst_done", load_done_o, 0);
        check("rst_err", {load_error_o, error_code_o}, 0);
        idle(2);
        reset_ni = 1'b1;

        // basic frame with leading junk
        send(8'h00);
        send(8'h5A);
        check("junk_halt", cpu_halt_o, 0);
        send(8'hA5);
        check("t1_halt_on", cpu_halt_o, 1);
        send(8'h02);
        exp_wr(0, 4'hC); exp_wr(1, 4'h3); exp_wr(2, 4'hE); exp_wr(3, 4'h7);
        send(8'h3C);
        check("t1_first_we", {mem_we_o, mem_addr_o, mem_data_o}, {1'b1, 5'd0, 4'hC});
        idle(2);
        send(8'h7E);
        idle(2);
        check("t1_halt_mid", cpu_halt_o, 1);
        rq.push_back(0);
        send(8'hBA);
        check("t1_done", load_done_o, 1);
        check("t1_halt_off", cpu_halt_o, 0);
        check("t1_no_err", {load_error_o, error_code_o}, 0);
        idle(1);
        check("t1_done_pulse", load_done_o, 0);

        // checksum mismatch
        exp_wr(0, 4'h2); exp_wr(1, 4'h1);
        rq.push_back(2);
        send(8'hA5); send(8'h01); send(8'h12); idle(2); send(8'h00);
        check("t2_err", {load_error_o, error_code_o}, {1'b1, 2'b10});
        check("t2_done", load_done_o, 0);
        check("t2_halt", cpu_halt_o, 0);

        // bad lengths, then a good frame carrying the sync value as data
        rq.push_back(1);
        send(8'hA5); send(8'h00);
        check("t3_len0", {load_error_o, error_code_o, cpu_halt_o}, {1'b1, 2'b01, 1'b0});
        rq.push_back(1);
        send(8'hA5);
        check("t3_err_clear", {load_error_o, error_code_o}, 0);
        send(8'h11);
        check("t3_len17", {load_error_o, error_code_o, cpu_halt_o}, {1'b1, 2'b01, 1'b0});
        send(8'hA5);
        check("t3_err_clear2", load_error_o, 0);
        send(8'h01);
        exp_wr(0, 4'h5); exp_wr(1, 4'hA);
        send(8'hA5);
        idle(2);
        check("t3_sync_as_data", cpu_halt_o, 1);
        rq.push_back(0);
        send(8'hA5);
        check("t3_done", {load_done_o, load_error_o}, 2'b10);

        // memory back-pressure
        mem_ready_i = 1'b0;
        send(8'hA5); send(8'h01);
        exp_wr(0, 4'hF); exp_wr(1, 4'h9);
        send(8'h9F);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) mem_ready_i = 1'b1;
            check("t4_stall_hold", {mem_we_o, mem_addr_o, mem_data_o}, {1'b1, 5'd0, 4'hF});
            idle(1);
        end
        idle(2);
        rq.push_back(0);
        send(8'h9F);
        check("t4_done", load_done_o, 1);

        // overrun while the high nibble is stalled
        send(8'hA5); send(8'h01);
        exp_wr(0, 4'hF);
        send(8'h9F);
        @(posedge clk_i);
        #1 mem_ready_i = 1'b0;
        check("t5_hi_pending", {mem_we_o, mem_addr_o, mem_data_o}, {1'b1, 5'd1, 4'h9});
        rq.push_back(3);
        send(8'h55);
        check("t5_we_drop", mem_we_o, 0);
        check("t5_err", {load_error_o, error_code_o, cpu_halt_o}, {1'b1, 2'b11, 1'b0});
        mem_ready_i = 1'b1;

        // inter-byte timeout
        rq.push_back(3);
        send(8'hA5); send(8'h01);
        repeat (15) @(posedge clk_i);
        #1;
        check("t6_before_to", {load_error_o, cpu_halt_o}, 2'b01);
        idle(1);
        check("t6_timeout", {load_error_o, error_code_o, cpu_halt_o}, {1'b1, 2'b11, 1'b0});

        // strobe on the timeout cycle wins
        send(8'hA5); send(8'h01);
        repeat (14) @(posedge clk_i);
        exp_wr(0, 4'h7); exp_wr(1, 4'h4);
        send(8'h47);
        check("t6_strobe_wins", {load_error_o, mem_we_o}, 2'b01);
        idle(2);
        rq.push_back(0);
        send(8'h47);
        check("t6_done", load_done_o, 1);

        // asynchronous reset while a write is pending
        mem_ready_i = 1'b0;
        send(8'hA5); send(8'h01); send(8'hC3);
        #2 reset_ni = 1'b0;
        #1;
        check("t7_rst_out", {mem_we_o, mem_addr_o, mem_data_o, cpu_halt_o, load_done_o, load_error_o, error_code_o}, 0);
        @(posedge clk_i);
        #1 reset_ni = 1'b1;
        mem_ready_i = 1'b1;
        send(8'hA5); send(8'h02);
        exp_wr(0, 4'h1); exp_wr(1, 4'h2); exp_wr(2, 4'h3); exp_wr(3, 4'h4);
        send(8'h21); idle(2); send(8'h43); idle(2);
        rq.push_back(0);
        send(8'h64);
        check("t7_done", load_done_o, 1);

        // maximum length frame, bytes 0x00,0x11..0xFF, sum 0xF8, last address 31
        send(8'hA5); send(8'h10);
        for (int i = 0; i < 16; i++) begin
            exp_wr(5'(2 * i), 4'(i));
            exp_wr(5'(2 * i + 1), 4'(i));
            send(8'(i * 17));
            idle(2);
        end
        rq.push_back(0);
        send(8'hF8);
        check("t8_done", {load_done_o, load_error_o, cpu_halt_o}, 3'b100);

        idle(3);
        check("writes_drained", wq.size(), 0);
        check("results_drained", rq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
